// File: rtl/axi4_burst_ram_slave_if.sv
// AXI4 write/read channel bundle (32-bit address, 32-bit data) for axi4_burst_ram_slave.
interface axi4_burst_ram_slave_if #(
    parameter int unsigned ID_W = 2
) ();
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output awid, awaddr, awlen, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi4_burst_ram_slave.sv
// AXI4 INCR-burst slave RAM, one burst at a time, byte-strobed 32-bit words.
// Define AXI4_SLV_RESP_CHK_EN to flag out-of-window/non-INCR/wlast errors with SLVERR.
module axi4_burst_ram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ID_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4_burst_ram_slave_if.slave axi
);
    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam logic [AW-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
    state_t state, state_nxt;

    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   idx, idx_inc, aw_idx, ar_idx;
    logic [7:0]      len, cnt;
    logic [ID_W-1:0] bid_q, rid_q;
    logic [31:0]     rdata_q;
    logic            rlast_q;
    logic [1:0]      bresp_q, rresp_q;
    logic            awready, arready, wready;
    logic            aw_hs, ar_hs, w_hs, r_hs, last_w;
    logic [31:0]     aw_off, ar_off;
    logic            aw_bad, ar_bad, wbad, werr, rbad, beat_err;

    assign aw_off  = axi.awaddr - BASE_ADDR;
    assign ar_off  = axi.araddr - BASE_ADDR;
    assign aw_idx  = aw_off[AW+1:2];
    assign ar_idx  = ar_off[AW+1:2];
    assign idx_inc = idx + IDX_ONE;
    assign last_w  = (cnt == len);
    assign aw_hs   = axi.awvalid && awready;
    assign ar_hs   = axi.arvalid && arready;
    assign w_hs    = axi.wvalid && wready;
    assign r_hs    = (state == RDATA) && axi.rready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        awready   = 1'b0;
        arready   = 1'b0;
        wready    = 1'b0;
        case (state)
            IDLE: begin
                awready = 1'b1;
                arready = !axi.awvalid;
                if (axi.awvalid)      state_nxt = WDATA;
                else if (axi.arvalid) state_nxt = RDATA;
            end
            WDATA: begin
                wready = 1'b1;
                if (axi.wvalid && last_w) state_nxt = WRESP;
            end
            WRESP: if (axi.bready) state_nxt = IDLE;
            RDATA: if (axi.rready && rlast_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            len     <= '0;
            cnt     <= '0;
            bid_q   <= '0;
            rid_q   <= '0;
            rdata_q <= '0;
            rlast_q <= 1'b0;
            bresp_q <= '0;
            rresp_q <= '0;
        end else begin
            if (aw_hs) begin
                bid_q <= axi.awid;
                len   <= axi.awlen;
                idx   <= aw_idx;
                cnt   <= '0;
            end else if (ar_hs) begin
                rid_q   <= axi.arid;
                len     <= axi.arlen;
                idx     <= ar_idx;
                cnt     <= '0;
                rdata_q <= ar_bad ? '0 : mem[ar_idx];
                rlast_q <= (axi.arlen == 8'd0);
                rresp_q <= ar_bad ? 2'b10 : 2'b00;
            end
            if (w_hs) begin
                idx <= idx_inc;
                cnt <= cnt + 8'd1;
                if (last_w) bresp_q <= (werr || beat_err) ? 2'b10 : 2'b00;
            end
            // Next beat is fetched on the handshake so rdata stays registered and stable under stall.
            if (r_hs) begin
                if (rlast_q) begin
                    rlast_q <= 1'b0;
                end else begin
                    idx     <= idx_inc;
                    cnt     <= cnt + 8'd1;
                    rdata_q <= rbad ? '0 : mem[idx_inc];
                    rlast_q <= ((cnt + 8'd1) == len);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_hs && !wbad) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (axi.wstrb[b]) mem[idx][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
        end
    end

`ifdef AXI4_SLV_RESP_CHK_EN
    assign aw_bad   = (aw_off[31:AW+2] != '0) || (axi.awburst != 2'b01);
    assign ar_bad   = (ar_off[31:AW+2] != '0) || (axi.arburst != 2'b01);
    assign beat_err = (axi.wlast != last_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            wbad <= 1'b0;
            werr <= 1'b0;
            rbad <= 1'b0;
        end else begin
            if (aw_hs)     begin wbad <= aw_bad; werr <= aw_bad; end
            else if (w_hs) werr <= werr || beat_err;
            if (ar_hs)     rbad <= ar_bad;
        end
    end
`else
    assign aw_bad   = 1'b0;
    assign ar_bad   = 1'b0;
    assign beat_err = 1'b0;
    assign wbad     = 1'b0;
    assign werr     = 1'b0;
    assign rbad     = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{aw_off[31:AW+2], ar_off[31:AW+2], axi.awburst, axi.arburst, axi.wlast};
`endif

    logic unused_lsb;
    assign unused_lsb = ^{aw_off[1:0], ar_off[1:0]};

    // Both valids follow the FSM state, so reset clears them with no extra registers.
    assign axi.awready = awready;
    assign axi.arready = arready;
    assign axi.wready  = wready;
    assign axi.bvalid  = (state == WRESP);
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = (state == RDATA);
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;
endmodule

// File: tb/tb_axi4_burst_ram_slave.sv
// Directed self-checking bench for axi4_burst_ram_slave: vector table plus burst corner sequences.
module tb_axi4_burst_ram_slave;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_burst_ram_slave_if #(.ID_W(2)) bus ();

    axi4_burst_ram_slave #(
        .BASE_ADDR(32'h8000_0000),
        .DEPTH(64),
        .ID_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .axi(bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] rbuf  [256];
    logic        rlbuf [256];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_phase(input logic [31:0] addr, input int unsigned len,
                            input logic [1:0] id, input logic [1:0] burst);
        int unsigned n = 0;
        bus.awaddr = addr; bus.awlen = 8'(len); bus.awid = id; bus.awburst = burst;
        bus.awvalid = 1'b1;
        #1;
        while (!bus.awready && n < 20) begin tick(); n++; end
        chk("aw_ready", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] addr, input int unsigned len,
                            input logic [1:0] id, input logic [1:0] burst);
        int unsigned n = 0;
        bus.araddr = addr; bus.arlen = 8'(len); bus.arid = id; bus.arburst = burst;
        bus.arvalid = 1'b1;
        #1;
        while (!bus.arready && n < 20) begin tick(); n++; end
        chk("ar_ready", bus.arready, 1);
        tick();
        bus.arvalid = 1'b0;
    endtask

    task automatic w_phase(input int unsigned len, input logic [31:0] d0, input int unsigned step,
                           input logic [3:0] strb, output int unsigned beats);
        beats = 0;
        for (int unsigned i = 0; i <= len; i++) begin
            int unsigned n = 0;
            bus.wdata = d0 + step * i; bus.wstrb = strb; bus.wlast = (i == len);
            bus.wvalid = 1'b1;
            #1;
            while (!bus.wready && n < 20) begin tick(); n++; end
            chk("w_ready", bus.wready, 1);
            if (!bus.wready) break;
            beats++;
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic b_phase(input logic [1:0] id, input logic [1:0] resp, input int unsigned hold);
        int unsigned n = 0;
        bus.bready = 1'b0;
        #1;
        while (!bus.bvalid && n < 20) begin tick(); n++; end
        chk("b_valid", bus.bvalid, 1);
        chk("b_id", bus.bid, id);
        chk("b_resp", bus.bresp, resp);
        for (int unsigned k = 0; k < hold; k++) begin
            tick();
            chk("b_hold_valid", bus.bvalid, 1);
            chk("b_hold_id", bus.bid, id);
            chk("b_hold_resp", bus.bresp, resp);
            chk("b_hold_awready", bus.awready, 0);
        end
        bus.bready = 1'b1;
        #1;
        tick();
        bus.bready = 1'b0;
        chk("b_clear", bus.bvalid, 0);
    endtask

    task automatic r_phase(input int unsigned len, input logic [1:0] id,
                           input bit toggle, input logic [1:0] resp);
        int unsigned got = 0;
        int unsigned cyc = 0;
        bit          stalled = 0;
        logic [31:0] hold_d = '0;
        logic        hold_l = 1'b0;
        while (got <= len && cyc < 4 * (len + 1) + 20) begin
            bus.rready = toggle ? ((cyc % 2) == 1) : 1'b1;
            #1;
            if (bus.rvalid) begin
                if (stalled) begin
                    chk("r_hold_data", bus.rdata, hold_d);
                    chk("r_hold_last", bus.rlast, hold_l);
                end
                if (bus.rready) begin
                    rbuf[got]  = bus.rdata;
                    rlbuf[got] = bus.rlast;
                    chk("r_id", bus.rid, id);
                    chk("r_resp", bus.rresp, resp);
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hold_d  = bus.rdata;
                    hold_l  = bus.rlast;
                end
            end
            tick();
            cyc++;
        end
        bus.rready = 1'b0;
        chk("r_beats", got, len + 1);
        chk("r_done", bus.rvalid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt [8];
        int unsigned nb;
        logic [31:0] exp6 [3];

        vt[0] = '{32'h8000_0014, 32'hAABB_CCDD, 4'b1111, 32'hAABB_CCDD};
        vt[1] = '{32'h8000_0014, 32'h1122_3344, 4'b0011, 32'hAABB_3344};
        vt[2] = '{32'h8000_0014, 32'h5566_7788, 4'b1000, 32'h55BB_3344};
        vt[3] = '{32'h8000_0014, 32'h0000_0000, 4'b0000, 32'h55BB_3344};
        vt[4] = '{32'h8000_0020, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
        vt[5] = '{32'h8000_0020, 32'h1234_5678, 4'b0100, 32'hDE34_BEEF};
        vt[6] = '{32'h8000_00FC, 32'h0F0F_0F0F, 4'b1111, 32'h0F0F_0F0F};
        vt[7] = '{32'h8000_00FC, 32'h0000_00AA, 4'b0001, 32'h0F0F_0FAA};

        bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0; bus.awid = '0; bus.awburst = 2'b01;
        bus.wvalid  = 0; bus.wdata  = '0; bus.wstrb = '0; bus.wlast = 0;
        bus.bready  = 0;
        bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.arid = '0; bus.arburst = 2'b01;
        bus.rready  = 0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_bid", bus.bid, 0);
        chk("rst_rid", bus.rid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_bresp", bus.bresp, 0);
        chk("rst_rresp", bus.rresp, 0);
        chk("rst_awready", bus.awready, 1);
        chk("rst_arready", bus.arready, 1);
        rst = 1'b0;
        tick();

        // 16-beat master pattern, read back with rready toggling every cycle
        aw_phase(32'h8000_0000, 15, 2'd0, 2'b01);
        w_phase(15, 32'h8000_0000, 4, 4'hF, nb);
        chk("t1_wbeats", nb, 16);
        b_phase(2'd0, 2'b00, 0);
        ar_phase(32'h8000_0000, 15, 2'd0, 2'b01);
        r_phase(15, 2'd0, 1, 2'b00);
        for (int unsigned i = 0; i < 16; i++) begin
            chk($sformatf("t1_rdata%0d", i), rbuf[i], 32'h8000_0000 + 4 * i);
            chk($sformatf("t1_rlast%0d", i), rlbuf[i], (i == 15) ? 1 : 0);
        end

        // B backpressure for 5 cycles
        aw_phase(32'h8000_0050, 0, 2'd2, 2'b01);
        w_phase(0, 32'h1234_5678, 0, 4'hF, nb);
        b_phase(2'd2, 2'b00, 5);
        ar_phase(32'h8000_0050, 0, 2'd1, 2'b01);
        r_phase(0, 2'd1, 0, 2'b00);
        chk("t2_rdata", rbuf[0], 32'h1234_5678);

        // AW and AR together: write wins, AR waits until IDLE
        bus.awaddr = 32'h8000_0078; bus.awlen = 8'd1; bus.awid = 2'd3; bus.awburst = 2'b01;
        bus.araddr = 32'h8000_0078; bus.arlen = 8'd1; bus.arid = 2'd2; bus.arburst = 2'b01;
        bus.awvalid = 1'b1;
        bus.arvalid = 1'b1;
        #1;
        chk("t3_arready_blocked", bus.arready, 0);
        chk("t3_awready", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
        #1;
        chk("t3_arready_wdata", bus.arready, 0);
        chk("t3_wready", bus.wready, 1);
        w_phase(1, 32'hC0DE_0000, 1, 4'hF, nb);
        chk("t3_arready_wresp", bus.arready, 0);
        b_phase(2'd3, 2'b00, 0);
        ar_phase(32'h8000_0078, 1, 2'd2, 2'b01);
        r_phase(1, 2'd2, 0, 2'b00);
        chk("t3_rdata0", rbuf[0], 32'hC0DE_0000);
        chk("t3_rdata1", rbuf[1], 32'hC0DE_0001);

        // Single-beat strobe vectors
        for (int unsigned i = 0; i < 8; i++) begin
            aw_phase(vt[i].addr, 0, 2'(i), 2'b01);
            w_phase(0, vt[i].data, 0, vt[i].strb, nb);
            b_phase(2'(i), 2'b00, 0);
            ar_phase(vt[i].addr, 0, 2'(i + 1), 2'b01);
            r_phase(0, 2'(i + 1), 0, 2'b00);
            chk($sformatf("vec%0d_rdata", i), rbuf[0], vt[i].exp);
            chk($sformatf("vec%0d_rlast", i), rlbuf[0], 1);
        end

        // Write wrapping past the top of RAM: words 62, 63, 0, 1
        aw_phase(32'h8000_00F8, 3, 2'd1, 2'b01);
        w_phase(3, 32'h0BAD_0000, 1, 4'hF, nb);
        b_phase(2'd1, 2'b00, 0);
        ar_phase(32'h8000_00F8, 3, 2'd0, 2'b01);
        r_phase(3, 2'd0, 0, 2'b00);
        for (int unsigned i = 0; i < 4; i++)
            chk($sformatf("t5_wrap%0d", i), rbuf[i], 32'h0BAD_0000 + i);
        ar_phase(32'h8000_0004, 0, 2'd0, 2'b01);
        r_phase(0, 2'd0, 0, 2'b00);
        chk("t5_word1", rbuf[0], 32'h0BAD_0003);

        // Reset in the middle of a read burst
        ar_phase(32'h8000_0000, 7, 2'd3, 2'b01);
        bus.rready = 1'b1;
        #1;
        chk("t5_mid_rdata0", bus.rdata, 32'h0BAD_0002);
        tick();
        #1;
        chk("t5_mid_rdata1", bus.rdata, 32'h0BAD_0003);
        tick();
        bus.rready = 1'b0;
        rst = 1'b1;
        tick();
        chk("t5_rst_rvalid", bus.rvalid, 0);
        chk("t5_rst_awready", bus.awready, 1);
        chk("t5_rst_rlast", bus.rlast, 0);
        chk("t5_rst_rdata", bus.rdata, 0);
        rst = 1'b0;
        tick();
        chk("t5_post_rvalid", bus.rvalid, 0);
        ar_phase(32'h8000_0000, 0, 2'd0, 2'b01);
        r_phase(0, 2'd0, 0, 2'b00);
        chk("t5_ram_kept", rbuf[0], 32'h0BAD_0002);

        // Out-of-window write and non-INCR read
        aw_phase(32'h9000_0000, 0, 2'd1, 2'b01);
        w_phase(0, 32'h7777_7777, 0, 4'hF, nb);
`ifdef AXI4_SLV_RESP_CHK_EN
        b_phase(2'd1, 2'b10, 0);
        ar_phase(32'h8000_0000, 2, 2'd2, 2'b00);
        r_phase(2, 2'd2, 0, 2'b10);
        exp6[0] = '0; exp6[1] = '0; exp6[2] = '0;
        for (int unsigned i = 0; i < 3; i++)
            chk($sformatf("t6_rdata%0d", i), rbuf[i], exp6[i]);
        ar_phase(32'h8000_0000, 0, 2'd0, 2'b01);
        r_phase(0, 2'd0, 0, 2'b00);
        chk("t6_ram_unchanged", rbuf[0], 32'h0BAD_0002);
`else
        b_phase(2'd1, 2'b00, 0);
        ar_phase(32'h8000_0000, 2, 2'd2, 2'b00);
        r_phase(2, 2'd2, 0, 2'b00);
        exp6[0] = 32'h7777_7777; exp6[1] = 32'h0BAD_0003; exp6[2] = 32'h8000_0008;
        for (int unsigned i = 0; i < 3; i++)
            chk($sformatf("t6_rdata%0d", i), rbuf[i], exp6[i]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
